// File: rtl/p5_core_if.sv
// p5_core_if: instruction-memory fetch channel of the p5 core.
//   im_req   core -> mem  fetch request, high only while the core is fetching
//   im_addr  core -> mem  word address of the fetch (the core PC)
//   im_ready mem -> core  im_data is valid this cycle
//   im_data  mem -> core  instruction word
// master = core side, slave = memory side.
interface p5_core_if #(
  parameter int DataSize = 32,
  parameter int MemSize  = 10
) ();
  logic                im_req;
  logic [MemSize-1:0]  im_addr;
  logic                im_ready;
  logic [DataSize-1:0] im_data;

  modport master (
    output im_req,
    output im_addr,
    input  im_ready,
    input  im_data
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ready,
    output im_data
  );
endinterface

// File: rtl/p5_core.sv
// p5_core: parametrised multi-cycle core. Sequencer FSM, fetch handshake,
// register file, ALU, sticky status flags, retired counter, debug read port.
//   i_clk        clock, all state changes on its rising edge
//   i_rst        asynchronous active-high reset
//   i_run        level, allows issue of the next instruction
//   im           fetch channel (master side)
//   i_dbg_raddr  debug register index
//   o_dbg_rdata  combinational read of register[i_dbg_raddr]
//   o_halted     core sits in HALT
//   o_illegal    sticky, an undecodable instruction was seen
//   o_overflow   sticky, signed overflow on ADD/SUB/ADDI
//   o_retired    completed-instruction count, saturating
//
// state  | meaning
// IDLE   | waiting for i_run
// FETCH  | im_req high, IR loads on the edge im_ready is sampled high
// DECODE | IR decoded, operands read from the register file
// EXEC   | ALU result and overflow flag latched
// WB     | register write, PC+1, retired+1
// HALT   | stopped after HALT or an illegal instruction, left only by reset
module p5_core #(
  parameter int DataSize = 32,
  parameter int AddrSize = 5,
  parameter int MemSize  = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_run,
  p5_core_if.master           im,
  input  logic [AddrSize-1:0] i_dbg_raddr,
  output logic [DataSize-1:0] o_dbg_rdata,
  output logic                o_halted,
  output logic                o_illegal,
  output logic                o_overflow,
  output logic [15:0]         o_retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_ALU  = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b101000;
  localparam logic [5:0] OP_ORI  = 6'b101100;
  localparam logic [5:0] OP_XORI = 6'b101011;
  localparam logic [5:0] OP_MOVI = 6'b100010;
  localparam logic [5:0] OP_HALT = 6'b110010;

  localparam logic [4:0] SUB_ADD   = 5'b00000;
  localparam logic [4:0] SUB_SUB   = 5'b00001;
  localparam logic [4:0] SUB_AND   = 5'b00010;
  localparam logic [4:0] SUB_XOR   = 5'b00011;
  localparam logic [4:0] SUB_OR    = 5'b00100;
  localparam logic [4:0] SUB_SLLI  = 5'b01000;
  localparam logic [4:0] SUB_SRLI  = 5'b01001;
  localparam logic [4:0] SUB_ROTRI = 5'b01011;

  localparam int NumRegs = 1 << AddrSize;
  localparam int Msb     = DataSize - 1;

  logic [2:0]          r_state;
  logic [MemSize-1:0]  r_pc;
  logic [DataSize-1:0] r_ir;
  logic [DataSize-1:0] r_regs [NumRegs];
  logic [DataSize-1:0] r_opa;
  logic [DataSize-1:0] r_opb;
  logic [DataSize-1:0] r_result;
  logic                r_illegal;
  logic                r_overflow;
  logic [15:0]         r_retired;

  logic [5:0]          w_opcode;
  logic [4:0]          w_sub;
  logic [4:0]          w_imm5;
  logic [AddrSize-1:0] w_rt;
  logic [AddrSize-1:0] w_ra;
  logic [AddrSize-1:0] w_rb;
  logic [DataSize-1:0] w_simm15;
  logic [DataSize-1:0] w_zimm15;
  logic [DataSize-1:0] w_simm20;
  logic [31:0]         w_rot_l;
  logic                w_legal;
  logic                w_is_halt;
  logic [DataSize-1:0] w_result;
  logic                w_ovf;
  logic [15:0]         w_retired_inc;
  logic                w_unused_ir;

  assign w_opcode = r_ir[30:25];
  assign w_sub    = r_ir[4:0];
  assign w_imm5   = r_ir[14:10];
  // 5-bit register fields: the size cast zero-pads or truncates to AddrSize
  assign w_rt     = AddrSize'(r_ir[24:20]);
  assign w_ra     = AddrSize'(r_ir[19:15]);
  assign w_rb     = AddrSize'(r_ir[14:10]);
  assign w_simm15 = {{(DataSize-15){r_ir[14]}}, r_ir[14:0]};
  assign w_zimm15 = {{(DataSize-15){1'b0}}, r_ir[14:0]};
  assign w_simm20 = {{(DataSize-20){r_ir[19]}}, r_ir[19:0]};
  // imm5 < 32 <= DataSize, so the amount is already reduced mod DataSize;
  // a zero rotate shifts left by DataSize, which yields 0 and leaves ra intact
  assign w_rot_l  = 32'(DataSize) - {27'd0, w_imm5};
  assign w_unused_ir = ^r_ir[9:5];

  assign w_retired_inc = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;

  always_comb begin
    w_legal   = 1'b0;
    w_is_halt = 1'b0;
    if (!r_ir[31]) begin
      case (w_opcode)
        OP_ALU: begin
          case (w_sub)
            SUB_ADD, SUB_SUB, SUB_AND, SUB_XOR, SUB_OR,
            SUB_SLLI, SUB_SRLI, SUB_ROTRI: w_legal = 1'b1;
            default: w_legal = 1'b0;
          endcase
        end
        OP_ADDI, OP_ORI, OP_XORI, OP_MOVI: w_legal = 1'b1;
        OP_HALT: begin
          w_legal   = 1'b1;
          w_is_halt = 1'b1;
        end
        default: w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (w_opcode)
      OP_ALU: begin
        case (w_sub)
          SUB_ADD: begin
            w_result = r_opa + r_opb;
            w_ovf    = (r_opa[Msb] == r_opb[Msb]) && (w_result[Msb] != r_opa[Msb]);
          end
          SUB_SUB: begin
            w_result = r_opa - r_opb;
            w_ovf    = (r_opa[Msb] != r_opb[Msb]) && (w_result[Msb] != r_opa[Msb]);
          end
          SUB_AND:   w_result = r_opa & r_opb;
          SUB_XOR:   w_result = r_opa ^ r_opb;
          SUB_OR:    w_result = r_opa | r_opb;
          SUB_SLLI:  w_result = r_opa << w_imm5;
          SUB_SRLI:  w_result = r_opa >> w_imm5;
          SUB_ROTRI: w_result = (r_opa >> w_imm5) | (r_opa << w_rot_l);
          default:   w_result = '0;
        endcase
      end
      OP_ADDI: begin
        w_result = r_opa + w_simm15;
        w_ovf    = (r_opa[Msb] == w_simm15[Msb]) && (w_result[Msb] != r_opa[Msb]);
      end
      OP_ORI:  w_result = r_opa | w_zimm15;
      OP_XORI: w_result = r_opa ^ w_zimm15;
      OP_MOVI: w_result = w_simm20;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_result   <= '0;
      r_illegal  <= 1'b0;
      r_overflow <= 1'b0;
      r_retired  <= '0;
      for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (im.im_ready) begin
            r_ir    <= im.im_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else if (w_is_halt) begin
            r_retired <= w_retired_inc;
            r_state   <= S_HALT;
          end else begin
            r_opa   <= r_regs[w_ra];
            r_opb   <= r_regs[w_rb];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result   <= w_result;
          r_overflow <= r_overflow | w_ovf;
          r_state    <= S_WB;
        end
        S_WB: begin
          r_regs[w_rt] <= r_result;
          r_pc         <= r_pc + MemSize'(1);
          r_retired    <= w_retired_inc;
          r_state      <= i_run ? S_FETCH : S_IDLE;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign im.im_req   = (r_state == S_FETCH);
  assign im.im_addr  = r_pc;
  assign o_dbg_rdata = r_regs[i_dbg_raddr];
  assign o_halted    = (r_state == S_HALT);
  assign o_illegal   = r_illegal;
  assign o_overflow  = r_overflow;
  assign o_retired   = r_retired;

endmodule

// File: doc/p5_core.md
# p5_core

Parametrised multi-cycle processor core. It succeeds the fixed-width single-path top that tied instruction memory, PC ticker, IR controller and register-file/ALU datapath together. The block integrates a sequencer FSM (FETCH/DECODE/EXEC/WB), a ready/request instruction-memory handshake, a parametrised register file and ALU, sticky status flags, a retired-instruction counter and a debug register read port. It sits between the instruction memory and the chip top.

## Interface
- DataSize, 32: datapath and instruction width; must be ≥ 32.
- AddrSize, 5: register index width; register file has 2^AddrSize entries.
- MemSize, 10: PC / instruction-address width, word addressed.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- run  in  1  level; 1 allows instruction issue.
- im_req  out  1  fetch request.
- im_addr  out  MemSize  fetch address; equals PC.
- im_ready  in  1  memory ready; im_data valid in the same cycle.
- im_data  in  DataSize  instruction word.
- dbg_raddr  in  AddrSize  debug register index.
- dbg_rdata  out  DataSize  combinational read of register[dbg_raddr].
- halted  out  1  core in HALT state.
- illegal  out  1  sticky; set by an undecodable instruction.
- overflow  out  1  sticky; signed overflow on ADD/SUB/ADDI.
- retired  out  16  count of completed instructions; saturates at 16'hFFFF.

## Operation
- Field decode from IR:
  - opcode = IR[30:25], rt = IR[24:20], ra = IR[19:15], rb = IR[14:10], sub = IR[4:0].
  - imm5 = IR[14:10], imm15 = IR[14:0], imm20 = IR[19:0].
  - Register fields are truncated or zero-padded to AddrSize.
- ALU group, opcode 6'b100000, result to rt:
  - sub 00000 ADD ra+rb; 00001 SUB ra−rb; 00010 AND; 00100 OR; 00011 XOR.
  - 01000 SLLI ra<<imm5; 01001 SRLI ra>>imm5 (logical); 01011 ROTRI ra rotate-right imm5.
  - Shift and rotate amounts are taken mod DataSize.
- ADDI, opcode 6'b101000: rt = ra + sign-extended imm15.
- ORI, opcode 6'b101100: rt = ra | zero-extended imm15.
- XORI, opcode 6'b101011: rt = ra ^ zero-extended imm15.
- MOVI, opcode 6'b100010: rt = sign-extended imm20.
- HALT, opcode 6'b110010: no writeback; counts as retired; enters HALT.
- Illegal instruction: IR[31]=1, any other opcode, or an undefined sub under 6'b100000.
  - Sets illegal; no writeback; not retired; enters HALT.
- Arithmetic is modulo 2^DataSize.
- overflow sets when operand signs match and the result sign differs (ADD, ADDI), or when operand signs differ and the result sign differs from ra (SUB). The write still occurs.
- All registers are general purpose; r0 is writable.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE → FETCH when run=1.
  - FETCH → DECODE on an edge where im_ready=1; IR ← im_data on that edge.
  - DECODE → EXEC: operands latched from the register file.
  - EXEC → WB: result and flags latched.
  - In WB: register write, PC ← PC+1 (wraps at 2^MemSize), retired increments.
  - WB → FETCH if run=1, otherwise IDLE.
  - From DECODE, HALT and illegal instructions go directly to HALT; PC is not incremented.
  - HALT is left only by reset.
- run deasserted mid-instruction: the current instruction completes; the core stops at the WB boundary.

## Timing
- Reset values:
  - State IDLE, PC=0, IR=0, all registers 0.
  - im_req=0, im_addr=0, halted=0, illegal=0, overflow=0, retired=0.
- im_req=1 only in FETCH. im_addr stays stable while im_req=1 until im_ready is sampled high.
- im_ready is ignored outside FETCH.
- Minimum instruction latency: 4 cycles (im_ready=1 on the first FETCH cycle). Each cycle of im_ready=0 adds one cycle.
- A register written in WB is visible to the next instruction's DECODE.
- dbg_rdata reflects a WB write from the cycle after that edge.
- halted=1 from the edge entering HALT.
- illegal and overflow update on the DECODE→HALT and EXEC→WB edges respectively.
- reset asserted at any time, including mid-FETCH with im_req high, drops im_req and all state asynchronously.
- After reset release, the first FETCH cycle is one cycle after run is sampled high.

## Test plan
- Reset then run=1, im_ready tied 1, program MOVI r1,5; MOVI r2,−3; ADD r3,r1,r2; HALT -> r3=2; retired=4; halted=1 at cycle 16; im_addr final=3.
- im_ready held low 3 cycles on the second fetch -> im_req and im_addr=1 stable throughout; that instruction takes 7 cycles.
- ADDI r1,r0,0x3FFF repeated until r1 passes 0x7FFFFFFF (DataSize=32) -> overflow=1 on the wrapping ADDI and stays 1; r1 wraps negative.
- ROTRI r2,r1,4 with r1=32'h0000_00F1 -> r2=32'h1000_000F; SRLI by 4 -> 32'h0000_000F.
- Instruction 32'h8000_0000 -> illegal=1, halted=1, retired unchanged, rt unchanged, no further im_req.
- Reset asserted mid-FETCH after 1000 instructions, with MemSize=4 and PC wrapped -> im_req=0 immediately; retired=0; PC=0; registers 0.
